// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: FSM states,
// instruction classes, opcode/funct constants and datapath control encodings.
package mc_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned COND_W   = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    IC_NOP    = 3'd0,
    IC_ALU    = 3'd1,
    IC_BRANCH = 3'd2,
    IC_JUMP   = 3'd3,
    IC_LOAD   = 3'd4,
    IC_STORE  = 3'd5
  } iclass_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [ALU_OP_W-1:0] ALU_ADDU = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUBU = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b1110;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b1111;

  localparam logic [COND_W-1:0] COND_BEQ  = 3'b001;
  localparam logic [COND_W-1:0] COND_BNE  = 3'b010;
  localparam logic [COND_W-1:0] COND_BGEZ = 3'b011;
  localparam logic [COND_W-1:0] COND_BGTZ = 3'b100;
  localparam logic [COND_W-1:0] COND_BLEZ = 3'b101;
  localparam logic [COND_W-1:0] COND_BLTZ = 3'b110;

  localparam logic [SEL_W-1:0] LD_WORD  = 2'b00;
  localparam logic [SEL_W-1:0] LD_BYTE  = 2'b01;
  localparam logic [SEL_W-1:0] LD_BYTEU = 2'b10;

  localparam logic [SEL_W-1:0] SH_SLL = 2'b00;
  localparam logic [SEL_W-1:0] SH_SRL = 2'b01;
  localparam logic [SEL_W-1:0] SH_SRA = 2'b10;

  localparam logic [SEL_W-1:0] BSEL_RT  = 2'b00;
  localparam logic [SEL_W-1:0] BSEL_IMM = 2'b01;
  localparam logic [SEL_W-1:0] BSEL_LUI = 2'b10;

  localparam logic [SEL_W-1:0] PC_SEQ    = 2'b00;
  localparam logic [SEL_W-1:0] PC_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] PC_TRAP   = 2'b11;

  typedef struct packed {
    iclass_e             iclass;
    logic [ALU_OP_W-1:0] alu_op;
    logic [SEL_W-1:0]    shift_op;
    logic [SEL_W-1:0]    b_in_sel;
    logic [COND_W-1:0]   condition;
    logic [SEL_W-1:0]    load_ext;
    logic                jump;
    logic                extend_sel;
    logic                shift_amount_sel;
    logic                rd_addr_sel;
    logic                alu_shift_sel;
    logic                rt_addr_sel;
    logic                ovf_chk;
    logic                byte_store;
  } ctrl_t;

  // Shifter operation from the low two funct bits (sll/srl/sra and their v-forms).
  function automatic logic [SEL_W-1:0] shift_op_of(input logic [1:0] fn_lo);
    case (fn_lo)
      2'b00:   return SH_SLL;
      2'b10:   return SH_SRL;
      default: return SH_SRA;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: IR fields to static control fields and
// instruction class. Anything not recognised decodes to IC_NOP.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] shamt,
  input  logic [5:0] func,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.iclass      = IC_ALU;
        ctrl.rd_addr_sel = 1'b1;
        case (func)
          FN_ADD:  begin ctrl.alu_op = ALU_ADD; ctrl.ovf_chk = 1'b1; end
          FN_ADDU: ctrl.alu_op = ALU_ADDU;
          FN_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.ovf_chk = 1'b1; end
          FN_SUBU: ctrl.alu_op = ALU_SUBU;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_XOR:  ctrl.alu_op = ALU_XOR;
          FN_NOR:  ctrl.alu_op = ALU_NOR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SLTU: ctrl.alu_op = ALU_SLTU;
          FN_SLL, FN_SRL, FN_SRA: begin
            ctrl.alu_shift_sel = 1'b1;
            ctrl.shift_op      = shift_op_of(func[1:0]);
            // Non-zero rs is illegal here; sll $0,$0,0 is the canonical nop.
            if (rs != '0 || (func == FN_SLL && rt == '0 && shamt == '0))
              ctrl.iclass = IC_NOP;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            ctrl.alu_shift_sel    = 1'b1;
            ctrl.shift_amount_sel = 1'b1;
            ctrl.shift_op         = shift_op_of(func[1:0]);
            if (shamt != '0) ctrl.iclass = IC_NOP;
          end
          default: ctrl.iclass = IC_NOP;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.iclass   = IC_ALU;
        ctrl.b_in_sel = BSEL_IMM;
        case (op)
          OP_ADDI:  begin ctrl.alu_op = ALU_ADD; ctrl.ovf_chk = 1'b1; ctrl.extend_sel = 1'b1; end
          OP_ADDIU: begin ctrl.alu_op = ALU_ADDU; ctrl.extend_sel = 1'b1; end
          OP_SLTI:  begin ctrl.alu_op = ALU_SLT;  ctrl.extend_sel = 1'b1; end
          OP_SLTIU: begin ctrl.alu_op = ALU_SLTU; ctrl.extend_sel = 1'b1; end
          OP_ANDI:  ctrl.alu_op = ALU_AND;
          OP_ORI:   ctrl.alu_op = ALU_OR;
          OP_XORI:  ctrl.alu_op = ALU_XOR;
          default:  begin ctrl.alu_op = ALU_ADDU; ctrl.b_in_sel = BSEL_LUI; end
        endcase
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        ctrl.iclass      = IC_BRANCH;
        ctrl.alu_op      = ALU_SUBU;
        ctrl.extend_sel  = 1'b1;
        ctrl.rt_addr_sel = (op != OP_BEQ && op != OP_BNE);
        case (op)
          OP_BEQ:  ctrl.condition = COND_BEQ;
          OP_BNE:  ctrl.condition = COND_BNE;
          OP_BLEZ: ctrl.condition = COND_BLEZ;
          OP_BGTZ: ctrl.condition = COND_BGTZ;
          default: begin
            if (rt == 5'd0)      ctrl.condition = COND_BLTZ;
            else if (rt == 5'd1) ctrl.condition = COND_BGEZ;
            else                 ctrl.iclass    = IC_NOP;
          end
        endcase
      end
      OP_J: begin
        ctrl.iclass = IC_JUMP;
        ctrl.jump   = 1'b1;
      end
      OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: begin
        ctrl.iclass     = (op == OP_SW || op == OP_SB) ? IC_STORE : IC_LOAD;
        ctrl.alu_op     = ALU_ADDU;
        ctrl.b_in_sel   = BSEL_IMM;
        ctrl.extend_sel = 1'b1;
        ctrl.byte_store = (op == OP_SB);
        ctrl.load_ext   = (op == OP_LB) ? LD_BYTE : (op == OP_LBU) ? LD_BYTEU : LD_WORD;
      end
      default: ctrl.iclass = IC_NOP;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing over a ready
// handshake with bus timeout. Optional overflow trap enabled by MC_OVF_TRAP_EN.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0180
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [4:0]          Rs,
  input  logic [4:0]          Rt,
  input  logic [4:0]          Shamt,
  input  logic [5:0]          Func,
  input  logic                Overflow_out,
  input  logic                branch_true,
  input  logic [1:0]          addr_lo,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [3:0]          mem_be,
  output logic                mem_addr_sel,
  output logic                ir_we,
  output logic                pc_we,
  output logic [SEL_W-1:0]    pc_src,
  output logic [3:0]          Rd_byte_w_en,
  output logic                Jump,
  output logic                Extend_sel,
  output logic                Shift_amount_sel,
  output logic                Rd_addr_sel,
  output logic                ALU_Shift_sel,
  output logic                Rt_addr_sel,
  output logic [SEL_W-1:0]    Shift_op,
  output logic [SEL_W-1:0]    B_in_sel,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic [COND_W-1:0]   condition,
  output logic [SEL_W-1:0]    load_ext,
  output logic                bus_err,
  output logic                exc,
  output logic [2:0]          state_o
);

  localparam int unsigned CNT_W        = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  // The PC mux takes the trap vector from the datapath; reject a misaligned one.
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_trap_vector_check
    $error("mc_controller: TRAP_VECTOR must be word aligned");
  end

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, dec_ctrl;
  logic [CNT_W-1:0]   cnt_q;
  logic               live_q;
  logic               ovf_q;
  logic               mem_wait;
  logic               timeout_hit;
  logic               drive_static;

  mc_decode u_decode (
    .op    (op),
    .rs    (Rs),
    .rt    (Rt),
    .shamt (Shamt),
    .func  (Func),
    .ctrl  (dec_ctrl)
  );

  // live_q keeps requests off for the first cycle after reset is sampled.
  assign mem_wait    = (((state_q == ST_FETCH) && live_q) || (state_q == ST_MEM)) && !mem_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && mem_wait && (cnt_q == CNT_W'(TIMEOUT_LAST));
  assign state_o     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      live_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bus_err <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (state_d != state_q) cnt_q <= '0;
      else if (mem_wait)      cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == ST_DECODE) ctrl_q <= dec_ctrl;
      if (state_q == ST_EXEC && ctrl_q.iclass == IC_ALU) ovf_q <= Overflow_out;
      if (timeout_hit) bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    drive_static     = 1'b0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_be           = '0;
    mem_addr_sel     = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    pc_src           = PC_SEQ;
    Rd_byte_w_en     = '0;
    Jump             = 1'b0;
    Extend_sel       = 1'b0;
    Shift_amount_sel = 1'b0;
    Rd_addr_sel      = 1'b0;
    ALU_Shift_sel    = 1'b0;
    Rt_addr_sel      = 1'b0;
    Shift_op         = '0;
    B_in_sel         = '0;
    ALU_op           = '0;
    condition        = '0;
    load_ext         = '0;
    exc              = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (live_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = ST_DECODE;
          end else if (timeout_hit) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        drive_static = 1'b1;
        case (ctrl_q.iclass)
          IC_BRANCH: begin
            pc_we   = branch_true;
            pc_src  = PC_BRANCH;
            state_d = ST_FETCH;
          end
          IC_JUMP: begin
            pc_we   = 1'b1;
            pc_src  = PC_JUMP;
            state_d = ST_FETCH;
          end
          IC_LOAD, IC_STORE: state_d = ST_MEM;
          IC_ALU: begin
`ifdef MC_OVF_TRAP_EN
            state_d = (ctrl_q.ovf_chk && Overflow_out) ? ST_TRAP : ST_WB;
`else
            state_d = ST_WB;
`endif
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        drive_static = 1'b1;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        if (ctrl_q.iclass == IC_STORE) begin
          mem_we = 1'b1;
          mem_be = ctrl_q.byte_store ? (4'b0001 << addr_lo) : 4'b1111;
        end else begin
          load_ext = ctrl_q.load_ext;
        end
        if (mem_ready)        state_d = (ctrl_q.iclass == IC_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout_hit) state_d = ST_HALT;
      end
      ST_WB: begin
        drive_static = 1'b1;
        if (ctrl_q.iclass == IC_LOAD) load_ext = ctrl_q.load_ext;
        // Signed overflow on add/addi/sub discards the result.
        Rd_byte_w_en = (ovf_q && ctrl_q.ovf_chk) ? 4'b0000 : 4'b1111;
        state_d      = ST_FETCH;
      end
`ifdef MC_OVF_TRAP_EN
      ST_TRAP: begin
        exc     = 1'b1;
        pc_we   = 1'b1;
        pc_src  = PC_TRAP;
        state_d = ST_FETCH;
      end
`endif
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    if (drive_static) begin
      Jump             = ctrl_q.jump;
      Extend_sel       = ctrl_q.extend_sel;
      Shift_amount_sel = ctrl_q.shift_amount_sel;
      Rd_addr_sel      = ctrl_q.rd_addr_sel;
      ALU_Shift_sel    = ctrl_q.alu_shift_sel;
      Rt_addr_sel      = ctrl_q.rt_addr_sel;
      Shift_op         = ctrl_q.shift_op;
      B_in_sel         = ctrl_q.b_in_sel;
      ALU_op           = ctrl_q.alu_op;
      condition        = ctrl_q.condition;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller (TIMEOUT_CYCLES=4); overflow
// expectations follow MC_OVF_TRAP_EN when it is defined.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0, Func = '0;
  logic [4:0] Rs = '0, Rt = '0, Shamt = '0;
  logic       Overflow_out = 1'b0, branch_true = 1'b0, mem_ready = 1'b0;
  logic [1:0] addr_lo = '0;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, bus_err, exc;
  logic       Jump, Extend_sel, Shift_amount_sel, Rd_addr_sel, ALU_Shift_sel, Rt_addr_sel;
  logic [3:0] mem_be, Rd_byte_w_en, ALU_op;
  logic [1:0] pc_src, Shift_op, B_in_sel, load_ext;
  logic [2:0] condition, state_o;

  int n_checks = 0;
  int n_pass   = 0;

  mc_controller #(.TIMEOUT_CYCLES(4), .TRAP_VECTOR(32'h0000_0180)) dut (
    .clk(clk), .rst(rst), .op(op), .Rs(Rs), .Rt(Rt), .Shamt(Shamt), .Func(Func),
    .Overflow_out(Overflow_out), .branch_true(branch_true), .addr_lo(addr_lo),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .Rd_byte_w_en(Rd_byte_w_en), .Jump(Jump), .Extend_sel(Extend_sel),
    .Shift_amount_sel(Shift_amount_sel), .Rd_addr_sel(Rd_addr_sel),
    .ALU_Shift_sel(ALU_Shift_sel), .Rt_addr_sel(Rt_addr_sel), .Shift_op(Shift_op),
    .B_in_sel(B_in_sel), .ALU_op(ALU_op), .condition(condition), .load_ext(load_ext),
    .bus_err(bus_err), .exc(exc), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Zero-wait fetch of one instruction, then through DECODE; returns in EXEC.
  task automatic issue(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] sh, input logic [5:0] f);
    op = o; Rs = s; Rt = t; Shamt = sh; Func = f;
    mem_ready = 1'b1;
    #1 check("fetch state", state_o, 0);
    check("fetch req/ir_we/pc_we/pc_src", {mem_req, ir_we, pc_we, pc_src}, 5'b11100);
    tick();
    mem_ready = 1'b0;
    #1 check("decode state", state_o, 1);
    check("decode mem_req", mem_req, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    #1 check("reset state", state_o, 0);
    check("reset mem_req", mem_req, 0);
    check("reset pc_we/ir_we", {pc_we, ir_we}, 0);
    check("reset Rd_byte_w_en", Rd_byte_w_en, 0);
    check("reset bus_err/exc", {bus_err, exc}, 0);
    rst = 1'b0;
    #1 check("release cycle mem_req", mem_req, 0);
    tick();

    // addu zero-wait: EXEC cycle 3, WB cycle 4, FETCH cycle 5
    issue(6'h00, 5'd1, 5'd2, 5'd3, 6'h21);
    #1 check("addu exec state", state_o, 2);
    check("addu alu_op", ALU_op, 4'b0000);
    check("addu rd_addr_sel", Rd_addr_sel, 1);
    tick();
    #1 check("addu wb state", state_o, 4);
    check("addu wb write", Rd_byte_w_en, 4'hF);
    check("addu wb alu_op", ALU_op, 4'b0000);
    tick();
    #1 check("addu back to fetch", state_o, 0);

    // lw with mem_ready two cycles late in MEM
    issue(6'h23, 5'd1, 5'd2, 5'd0, 6'h00);
    #1 check("lw exec b_in/ext", {B_in_sel, Extend_sel}, 3'b011);
    tick();
    #1 check("lw mem state", state_o, 3);
    check("lw mem req/addr_sel/we", {mem_req, mem_addr_sel, mem_we}, 3'b110);
    check("lw load_ext", load_ext, 2'b00);
    tick();
    #1 check("lw wait2 mem_req", mem_req, 1);
    tick();
    mem_ready = 1'b1;
    #1 check("lw wait3 req/state", {mem_req, state_o}, 4'b1011);
    tick();
    mem_ready = 1'b0;
    #1 check("lw wb state", state_o, 4);
    check("lw wb mem_req", mem_req, 0);
    check("lw wb write", Rd_byte_w_en, 4'hF);
    tick();
    #1 check("lw back to fetch", state_o, 0);

    // lb: sign-extending load
    issue(6'h20, 5'd1, 5'd2, 5'd0, 6'h00);
    tick();
    mem_ready = 1'b1;
    #1 check("lb mem load_ext", load_ext, 2'b01);
    tick();
    mem_ready = 1'b0;
    #1 check("lb wb load_ext", {state_o, load_ext}, 5'b10001);
    tick();

    // sb to lane 2, then sw
    issue(6'h28, 5'd1, 5'd2, 5'd0, 6'h00);
    tick();
    addr_lo = 2'd2; mem_ready = 1'b1;
    #1 check("sb mem_be", mem_be, 4'b0100);
    check("sb mem_we", mem_we, 1);
    check("sb no reg write", Rd_byte_w_en, 0);
    tick();
    mem_ready = 1'b0; addr_lo = 2'd0;
    #1 check("sb back to fetch", state_o, 0);
    check("sb fetch no reg write", Rd_byte_w_en, 0);
    issue(6'h2b, 5'd1, 5'd2, 5'd0, 6'h00);
    tick();
    addr_lo = 2'd3; mem_ready = 1'b1;
    #1 check("sw mem_be", {mem_we, mem_be}, 5'b11111);
    tick();
    mem_ready = 1'b0; addr_lo = 2'd0;

    // add with signed overflow
    issue(6'h00, 5'd1, 5'd2, 5'd0, 6'h20);
    Overflow_out = 1'b1;
    #1 check("add alu_op", ALU_op, 4'b1110);
    tick();
    Overflow_out = 1'b0;
`ifdef MC_OVF_TRAP_EN
    #1 check("add ovf trap state", state_o, 5);
    check("add ovf exc/pc_we/pc_src", {exc, pc_we, pc_src}, 4'b1111);
    check("add ovf trap no write", Rd_byte_w_en, 0);
    tick();
    #1 check("trap exc one cycle", {exc, state_o}, 4'b0000);
`else
    #1 check("add ovf wb state", state_o, 4);
    check("add ovf write suppressed", Rd_byte_w_en, 0);
    check("add ovf exc", exc, 0);
    tick();
    #1 check("add ovf back to fetch", state_o, 0);
`endif

    // addu with overflow still writes
    issue(6'h00, 5'd1, 5'd2, 5'd0, 6'h21);
    Overflow_out = 1'b1;
    tick();
    Overflow_out = 1'b0;
    #1 check("addu ovf still writes", Rd_byte_w_en, 4'hF);
    tick();

    // beq taken, bne not taken
    issue(6'h04, 5'd1, 5'd2, 5'd0, 6'h00);
    branch_true = 1'b1;
    #1 check("beq pc_we/pc_src", {pc_we, pc_src}, 3'b101);
    check("beq condition/alu_op", {condition, ALU_op}, 7'b001_0001);
    tick();
    branch_true = 1'b0;
    #1 check("beq back to fetch", state_o, 0);
    issue(6'h05, 5'd1, 5'd2, 5'd0, 6'h00);
    #1 check("bne not taken", {pc_we, condition}, 4'b0010);
    tick();

    // j
    issue(6'h02, 5'd0, 5'd0, 5'd0, 6'h00);
    #1 check("j Jump/pc_we/pc_src", {Jump, pc_we, pc_src}, 4'b1110);
    tick();
    #1 check("j back to fetch", state_o, 0);

    // undefined opcode: EXEC then FETCH, no write
    issue(6'h3f, 5'd0, 5'd0, 5'd0, 6'h00);
    #1 check("undef exec state", state_o, 2);
    tick();
    #1 check("undef back to fetch", {state_o, Rd_byte_w_en}, 7'b000_0000);

    // completion on the limit cycle wins over the timeout
    tick(); tick(); tick();
    mem_ready = 1'b1;
    #1 check("limit completes ir_we", {ir_we, state_o}, 4'b1000);
    tick();
    mem_ready = 1'b0;
    #1 check("limit no bus_err", {bus_err, state_o}, 4'b0001);
    tick(); tick();

    // reset in the middle of a store wait
    issue(6'h2b, 5'd1, 5'd2, 5'd0, 6'h00);
    tick();
    #1 check("sw waiting mem_we", mem_we, 1);
    rst = 1'b1;
    tick();
    #1 check("rst mid-mem state", state_o, 0);
    check("rst mid-mem req/we", {mem_req, mem_we}, 2'b00);
    rst = 1'b0;
    tick();
    #1 check("after rst mem_req", {mem_req, state_o}, 4'b1000);

    // timeout in FETCH with mem_ready stuck low
    tick(); tick(); tick();
    #1 check("3 waits no halt", {bus_err, state_o}, 4'b0000);
    tick();
    #1 check("timeout halt", {bus_err, state_o}, 4'b1110);
    check("halt mem_req", mem_req, 0);
    mem_ready = 1'b1;
    tick();
    #1 check("halt stays", {state_o, mem_req, ir_we}, 5'b11000);
    mem_ready = 1'b0;
    rst = 1'b1;
    tick();
    #1 check("rst clears bus_err", {bus_err, state_o}, 4'b0000);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
